// File: rtl/clk_rate_meter.sv
// clk_rate_meter
//   Counts rising edges on NCH asynchronous inputs over a fixed gate window of
//   GATE clk125 cycles. At the end of every window the counts are latched into
//   rate together with saturation (rate_ovf) and dead-input (rate_zero) flags,
//   and rate_valid pulses for one cycle. Windows run back to back.
//
// Ports
//   clk125      reference clock (only clock)
//   reset_in_n  asynchronous active-low reset
//   enable      run enable; low freezes gate and edge counters, outputs hold
//   clear       restart the current window (gate and edge counters to zero)
//   sig_in      NCH asynchronous measured inputs
//   rate        latched counts, channel k at [k*CW +: CW]; all ones after reset
//   rate_valid  one-cycle pulse when rate/rate_ovf/rate_zero update
//   rate_ovf    channel count reached 2^CW-1 in the latched window
//   rate_zero   channel latched count is zero
//   minmax_clr  (CLK_RATE_METER_MINMAX_EN) reset the min/max trackers
//   rate_min    (CLK_RATE_METER_MINMAX_EN) per-channel minimum latched rate
//   rate_max    (CLK_RATE_METER_MINMAX_EN) per-channel maximum latched rate
//
// Build option: define CLK_RATE_METER_MINMAX_EN to add min/max tracking.

module clk_rate_meter #(
  parameter int NCH  = 4,
  parameter int CW   = 24,
  parameter int GATE = 1250000
) (
  input  logic              clk125,
  input  logic              reset_in_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [NCH-1:0]    sig_in,
`ifdef CLK_RATE_METER_MINMAX_EN
  input  logic              minmax_clr,
  output logic [NCH*CW-1:0] rate_min,
  output logic [NCH*CW-1:0] rate_max,
`endif
  output logic [NCH*CW-1:0] rate,
  output logic              rate_valid,
  output logic [NCH-1:0]    rate_ovf,
  output logic [NCH-1:0]    rate_zero
);

  // Gate counter is sized from GATE alone so small result widths still work
  // with long windows.
  localparam int GW = $clog2(GATE);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE - 1);
  localparam logic [CW-1:0] CMAX = '1;

  logic [NCH-1:0] s1, s2, s3;
  logic [NCH-1:0] edge_hit;
  logic           armed;
  logic [GW-1:0]  gate_cnt;
  logic [CW-1:0]  cnt     [NCH];
  logic [CW-1:0]  cnt_inc [NCH];
  logic           run;
  logic           latch;

  assign edge_hit = s2 & ~s3;

  // armed holds off counting for the first cycle after reset release so the
  // window starts on a settled, fully clocked state.
  assign run   = armed & enable;
  assign latch = run & ~clear & (gate_cnt == GATE_LAST);

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      cnt_inc[k] = cnt[k];
      if (cnt[k] != CMAX)
        cnt_inc[k] = cnt[k] + {{(CW-1){1'b0}}, edge_hit[k]};
    end
  end

  always_ff @(posedge clk125 or negedge reset_in_n) begin
    if (!reset_in_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk125 or negedge reset_in_n) begin
    if (!reset_in_n) begin
      armed      <= 1'b0;
      gate_cnt   <= '0;
      rate       <= '1;
      rate_valid <= 1'b0;
      rate_ovf   <= '0;
      rate_zero  <= '0;
      for (int k = 0; k < NCH; k++) cnt[k] <= '0;
    end else begin
      armed      <= 1'b1;
      rate_valid <= 1'b0;
      if (clear) begin
        // An edge coincident with clear is dropped along with the window.
        gate_cnt <= '0;
        for (int k = 0; k < NCH; k++) cnt[k] <= '0;
      end else if (run) begin
        if (latch) begin
          gate_cnt   <= '0;
          rate_valid <= 1'b1;
          for (int k = 0; k < NCH; k++) begin
            cnt[k]            <= '0;
            rate[k*CW +: CW]  <= cnt_inc[k];
            // Counts never wrap, so reaching full scale at any point in the
            // window shows up as a full-scale latched value.
            rate_ovf[k]       <= (cnt_inc[k] == CMAX);
            rate_zero[k]      <= (cnt_inc[k] == '0);
          end
        end else begin
          gate_cnt <= gate_cnt + GW'(1);
          for (int k = 0; k < NCH; k++) cnt[k] <= cnt_inc[k];
        end
      end
    end
  end

`ifdef CLK_RATE_METER_MINMAX_EN
  always_ff @(posedge clk125 or negedge reset_in_n) begin
    if (!reset_in_n) begin
      rate_min <= '1;
      rate_max <= '0;
    end else if (minmax_clr) begin
      rate_min <= '1;
      rate_max <= '0;
    end else if (latch) begin
      for (int k = 0; k < NCH; k++) begin
        if (cnt_inc[k] < rate_min[k*CW +: CW]) rate_min[k*CW +: CW] <= cnt_inc[k];
        if (cnt_inc[k] > rate_max[k*CW +: CW]) rate_max[k*CW +: CW] <= cnt_inc[k];
      end
    end
  end
`endif

endmodule

// File: doc/clk_rate_meter.md
CLK_RATE_METER -- requirements
Module: clk_rate_meter

Interface
REQ-001 Parameter NCH, default 4: number of measured channels, range 1..32.
REQ-002 Parameter CW, default 24: per-channel result and counter width, range 4..32.
REQ-003 Parameter GATE, default 1250000: gate window length in clk125 cycles (10 ms at 125 MHz), range 2..2^CW.
REQ-004 clk125  in  1  reference clock; only clock in the block.
REQ-005 reset_in_n  in  1  reset, asynchronous, active-low.
REQ-006 enable  in  1  synchronous run enable; low freezes the gate counter and edge counters.
REQ-007 clear  in  1  synchronous restart of the current window.
REQ-008 sig_in  in  NCH  asynchronous measured signals (divided clocks or strobes).
REQ-009 rate  out  NCH*CW  latched edge counts; channel k occupies bits [k*CW +: CW].
REQ-010 rate_valid  out  1  one-cycle pulse when rate is updated.
REQ-011 rate_ovf  out  NCH  per-channel saturation flag for the latched window.
REQ-012 rate_zero  out  NCH  per-channel flag, set when the latched count is 0 (dead or stuck input).

Function
REQ-013 Each sig_in bit SHALL pass through a 2-FF synchroniser plus one delay register; a rising edge is s2 & ~s3.
- Latency from input edge to counter increment: 3 clk125 cycles.
REQ-014 Edges SHALL be counted without loss for inputs whose high and low phases each last at least 2 clk125 periods.
REQ-015 The gate counter SHALL count 0..GATE-1 while enable=1 and wrap to 0.
- There is no dead time between windows.
REQ-016 In the cycle where the gate counter equals GATE-1 (the latch cycle):
- each channel's rate SHALL load counter+edge, saturated to 2^CW-1;
- its counter SHALL be cleared to 0.
REQ-017 rate_valid SHALL pulse in the cycle after the latch cycle; rate, rate_ovf and rate_zero update together in that same cycle.
REQ-018 Counters SHALL saturate at 2^CW-1 and never wrap.
- rate_ovf[k] is set if channel k reached 2^CW-1 during the window.
REQ-019 rate_zero[k] SHALL equal (latched rate[k]==0).
REQ-020 While enable=0:
- edges SHALL be ignored;
- the gate counter and edge counters hold;
- outputs hold;
- no rate_valid is produced.
REQ-021 clear=1 SHALL zero the gate counter and all edge counters in the next cycle without updating the outputs.
- clear takes priority over the latch cycle and over enable.
REQ-022 An edge arriving in the same cycle as clear SHALL be discarded.

Reset
REQ-023 Asserting reset_in_n low SHALL immediately set:
- rate to all ones (marks the result as unknown);
- rate_valid, rate_ovf and rate_zero to 0;
- the gate counter, edge counters and synchroniser registers to 0.
REQ-024 After reset release, the first rate_valid SHALL occur exactly GATE+1 cycles after the first enabled cycle.

Configuration
REQ-025 Macro CLK_RATE_METER_MINMAX_EN, when defined, SHALL add the following:
- input minmax_clr (1 bit);
- outputs rate_min and rate_max (NCH*CW each);
- rate_min/rate_max track the per-channel minimum/maximum of every latched rate, updated in the rate_valid cycle;
- minmax_clr and reset set rate_min to all ones and rate_max to 0.
REQ-026 Without CLK_RATE_METER_MINMAX_EN:
- those ports and registers SHALL be absent;
- all other behaviour is identical.

Verification (bench uses GATE=100, CW=8, NCH=4 unless stated)
REQ-027 sig_in[0] square wave with period 10 cycles, enable=1 -> rate[0]=10 every window, rate_valid every 100 cycles, rate_zero[0]=0.
REQ-028 sig_in[1] held high from reset -> rate[1]=0, rate_zero[1]=1, rate_ovf[1]=0.
REQ-029 CW=4, sig_in[2] with period 4 (25 edges per window) -> rate[2]=15, rate_ovf[2]=1.
REQ-030 clear pulsed at gate count 50 -> no rate_valid at the old boundary, next rate_valid 101 cycles after clear, rate unchanged until then.
REQ-031 reset_in_n pulled low mid-window at gate count 60 -> same cycle: rate=0xFF per channel, flags 0; first rate_valid 101 cycles after release.
REQ-032 CLK_RATE_METER_MINMAX_EN defined, sig_in[0] alternating period 10 and 20 across windows -> rate_min[0]=5, rate_max[0]=10; minmax_clr -> 0xFF/0x00.
